// File: rtl/match_event_logger_if.sv
// Event-logger port bundle: match pulses and pop requests in, FIFO head and status out.
// The logger uses the slave modport; whatever drives found/rd_en uses master.
interface match_event_logger_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             found;
  logic             rd_en;
  logic [TS_W-1:0]  rd_data;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic [15:0]      match_count;

  modport master (
    output found, rd_en,
    input  rd_data, empty, full, level, overflow, match_count
  );

  modport slave (
    input  found, rd_en,
    output rd_data, empty, full, level, overflow, match_count
  );
endinterface

// File: rtl/match_event_logger.sv
// Timestamps each match pulse into a first-word-fall-through FIFO; overflow is sticky.
// MATCH_LOG_DROP_OLDEST_EN: when full, evict the oldest entry instead of dropping the new event.
module match_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input logic             clk,
  input logic             reset,
  match_event_logger_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0]   LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]   LVL_ONE  = LW'(1);
  localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
  localparam logic [TS_W-1:0] TS_ONE   = TS_W'(1);

  logic [TS_W-1:0] mem_q [DEPTH];
  logic [TS_W-1:0] ts_q, ts_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     count_q, count_d;
  logic            wr_en;
  logic            pop;
  logic            push_ok;
  logic            empty_w;
  logic            full_w;

  assign empty_w = (level_q == '0);
  assign full_w  = (level_q == LVL_FULL);
  assign pop     = bus.rd_en && !empty_w;
  // A push into a full FIFO only fits when the head leaves on the same edge.
  assign push_ok = bus.found && (!full_w || pop);

  always_comb begin
    ts_d       = ts_q + TS_ONE;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    wr_en      = 1'b0;

    if (bus.found && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end

    if (push_ok) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    if (push_ok && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (!push_ok && pop) begin
      level_d = level_q - LVL_ONE;
    end

    if (bus.found && full_w && !pop) begin
      overflow_d = 1'b1;
`ifdef MATCH_LOG_DROP_OLDEST_EN
      // Full means wr_ptr == rd_ptr, so the new entry overwrites the oldest slot.
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
    end else begin
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_ptr_q] <= ts_q;
    end
  end

  assign bus.rd_data     = mem_q[rd_ptr_q];
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.level       = level_q;
  assign bus.overflow    = overflow_q;
  assign bus.match_count = count_q;
endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed stimulus against a queue-based reference model; a monitor scores outputs.
module tb_match_event_logger;
  localparam int DEPTH = 8;
`ifdef MATCH_LOG_DROP_OLDEST_EN
  localparam bit DROP_OLDEST = 1'b1;
`else
  localparam bit DROP_OLDEST = 1'b0;
`endif

  typedef struct {
    bit known;
    int level;
    bit ovf;
    int cnt;
  } status_t;

  logic clk;
  logic reset;

  match_event_logger_if #(.DEPTH(DEPTH), .TS_W(16)) bus16 ();
  match_event_logger_if #(.DEPTH(DEPTH), .TS_W(4))  bus4 ();

  match_event_logger #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus16.slave)
  );
  match_event_logger #(.DEPTH(DEPTH), .TS_W(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  assign bus4.found = bus16.found;
  assign bus4.rd_en = bus16.rd_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain queue of timestamps, edge counter since reset.
  int unsigned q_m[$];
  int unsigned ts_m;
  bit          ovf_m;
  int          cnt_m;
  bit          known_m;

  status_t     st_q[$];
  int unsigned data_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit f, input bit r);
    if (rst) begin
      q_m.delete();
      ts_m    = 0;
      ovf_m   = 1'b0;
      cnt_m   = 0;
      known_m = 1'b1;
      return;
    end
    if (f && cnt_m < 65535) cnt_m++;
    if (r && q_m.size() > 0) void'(q_m.pop_front());
    if (f) begin
      if (q_m.size() == DEPTH) begin
        ovf_m = 1'b1;
        if (DROP_OLDEST) begin
          void'(q_m.pop_front());
          q_m.push_back(ts_m);
        end
      end else begin
        q_m.push_back(ts_m);
      end
    end
    ts_m = (ts_m + 1) % 65536;
  endtask

  // One clock cycle: drive inputs, record expectations for the monitor, advance the model.
  task automatic cycle(input bit rst, input bit f, input bit r);
    status_t s;
    @(negedge clk);
    #1;
    reset        = rst;
    bus16.found  = f;
    bus16.rd_en  = r;
    s.known = known_m;
    s.level = q_m.size();
    s.ovf   = ovf_m;
    s.cnt   = cnt_m;
    st_q.push_back(s);
    if (!rst && r && known_m && q_m.size() > 0) data_q.push_back(q_m[0]);
    model_edge(rst, f, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: samples between the stimulus update and the next rising edge.
  initial begin
    status_t s;
    int unsigned e;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() == 0) continue;
      s = st_q.pop_front();
      if (s.known) begin
        chk("level",       bus16.level,       s.level);
        chk("empty",       bus16.empty,       s.level == 0);
        chk("full",        bus16.full,        s.level == DEPTH);
        chk("overflow",    bus16.overflow,    s.ovf);
        chk("match_count", bus16.match_count, s.cnt);
        chk("level_ts4",   bus4.level,        s.level);
      end
      if (!reset && bus16.rd_en && !bus16.empty) begin
        if (data_q.size() == 0) begin
          chk("unexpected_pop", 1, 0);
        end else begin
          e = data_q.pop_front();
          chk("rd_data",     bus16.rd_data, e);
          chk("rd_data_ts4", bus4.rd_data,  e % 16);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    bus16.found = 1'b0;
    bus16.rd_en = 1'b0;
    known_m     = 1'b0;
    ts_m        = 0;
    ovf_m       = 1'b0;
    cnt_m       = 0;

    // Reset, events on post-reset edges 3 and 5, then two pops.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    idle(2);

    // Nine events into an 8-deep FIFO, then drain past empty.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);

    // Full FIFO with simultaneous push and pop.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    idle(1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1);

    // Pops on an empty FIFO, then push+pop while empty.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    idle(1);
    cycle(1'b0, 1'b0, 1'b1);

    // Timestamp wrap: edge 17 on the 4-bit instance logs 1.
    cycle(1'b1, 1'b0, 1'b0);
    idle(17);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    idle(1);

    // Level 5 with overflow set, then reset coinciding with an event.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    idle(2);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 40);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b0, 1'b1);
    idle(3);

    chk("pending_reads", data_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
